// File: rtl/sntc_ldpc_iter_pkg.sv
// Shared types for the LDPC iteration controller: FSM state encoding and
// the default number of fractional bits in the stall IIR accumulator.
package sntc_ldpc_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ITER     = 2'd1,
        ST_WAIT_SYN = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int IIR_FRAC_DEF = 8;

endpackage

// File: rtl/sntc_ldpc_iter_ctrl_if.sv
// Bundle of control/status signals between the iteration controller (slave)
// and the host plus datapath that drive it (master).
interface sntc_ldpc_iter_ctrl_if #(
    parameter int SUM_LEN = 8,
    parameter int HAM_LEN = 16
);
    logic               start_dec;
    logic [HAM_LEN-1:0] loop_max;
    logic [2:0]         stall_shift;
    logic [3:0]         stall_limit;
    logic               iter_start;
    logic               syn_valid;
    logic [SUM_LEN-1:0] sum_mm;
    logic               busy;
    logic               done;
    logic               pass_fail;
    logic               stalled;
    logic [HAM_LEN-1:0] iter_cnt;

    modport master (
        output start_dec, loop_max, stall_shift, stall_limit, syn_valid, sum_mm,
        input  iter_start, busy, done, pass_fail, stalled, iter_cnt
    );

    modport slave (
        input  start_dec, loop_max, stall_shift, stall_limit, syn_valid, sum_mm,
        output iter_start, busy, done, pass_fail, stalled, iter_cnt
    );
endinterface

// File: rtl/sntc_ldpc_stall_iir.sv
// Smoothed syndrome-weight tracker: an IIR average of sum_mm and a counter of
// consecutive iterations that failed to improve on it. Built only when
// SNTC_ITER_STALL_DET_EN is defined.
module sntc_ldpc_stall_iir
    import sntc_ldpc_iter_pkg::*;
#(
    parameter int SUM_LEN  = 8,
    parameter int IIR_FRAC = IIR_FRAC_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               init,
    input  logic               upd,
    input  logic [SUM_LEN-1:0] sum_mm,
    input  logic [2:0]         shift_in,
    input  logic [3:0]         limit_in,
    output logic               stall_hit
);

    localparam int W = SUM_LEN + IIR_FRAC;

    logic [W-1:0]   iir_q, iir_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     limit_q, limit_d;
    logic [2:0]     shift_q, shift_d;
    logic           first_q, first_d;

    logic [W-1:0]   target;
    logic signed [W:0] diff;
    logic signed [W:0] step;
    logic [3:0]     cnt_inc;

    // The first sample of a codeword only seeds the average; it cannot count
    // as a non-improving iteration because there is nothing to compare against.
    always_comb begin
        target    = {sum_mm, {IIR_FRAC{1'b0}}};
        diff      = $signed({1'b0, target}) - $signed({1'b0, iir_q});
        step      = diff >>> shift_q;
        cnt_inc   = (target >= iir_q) ? ((cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1) : 4'd0;
        stall_hit = (limit_q != 4'd0) && !first_q && (cnt_inc == limit_q);

        iir_d   = iir_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        shift_d = shift_q;
        first_d = first_q;

        if (init) begin
            iir_d   = '0;
            cnt_d   = 4'd0;
            first_d = 1'b1;
            limit_d = limit_in;
            shift_d = shift_in;
        end else if (upd) begin
            first_d = 1'b0;
            if (first_q) begin
                iir_d = target;
            end else begin
                iir_d = W'($signed({1'b0, iir_q}) + step);
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            iir_q   <= '0;
            cnt_q   <= 4'd0;
            limit_q <= 4'd0;
            shift_q <= 3'd0;
            first_q <= 1'b1;
        end else begin
            iir_q   <= iir_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            shift_q <= shift_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/sntc_ldpc_iter_ctrl.sv
// LDPC decoder iteration controller: sequences iterations until convergence,
// loop limit or (with SNTC_ITER_STALL_DET_EN defined) IIR-based stall detection.
module sntc_ldpc_iter_ctrl
    import sntc_ldpc_iter_pkg::*;
#(
    parameter int MM       = 'h000a8,
    parameter int SUM_LEN  = $clog2(MM + 1),
    parameter int HAM_LEN  = 16,
    parameter int IIR_FRAC = IIR_FRAC_DEF
) (
    input logic                  clk,
    input logic                  clr,
    sntc_ldpc_iter_ctrl_if.slave bus
);

    state_t             state_q, state_d;
    logic [HAM_LEN-1:0] iter_cnt_q, iter_cnt_d;
    logic [HAM_LEN-1:0] loop_max_q, loop_max_d;
    logic [HAM_LEN-1:0] cnt_inc;
    logic               pass_fail_q, pass_fail_d;
    logic               stalled_q, stalled_d;
    logic               start_acc;
    logic               syn_upd;
    logic               stall_hit;

    assign cnt_inc = (iter_cnt_q == '1) ? iter_cnt_q : iter_cnt_q + HAM_LEN'(1);

`ifdef SNTC_ITER_STALL_DET_EN
    sntc_ldpc_stall_iir #(
        .SUM_LEN  (SUM_LEN),
        .IIR_FRAC (IIR_FRAC)
    ) u_stall (
        .clk       (clk),
        .clr       (clr),
        .init      (start_acc),
        .upd       (syn_upd),
        .sum_mm    (bus.sum_mm),
        .shift_in  (bus.stall_shift),
        .limit_in  (bus.stall_limit),
        .stall_hit (stall_hit)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.stall_shift, bus.stall_limit, start_acc, syn_upd};
    assign stall_hit  = 1'b0;
`endif

    // Termination checks are ordered: convergence beats the loop limit,
    // which beats stall detection.
    always_comb begin
        state_d     = state_q;
        iter_cnt_d  = iter_cnt_q;
        loop_max_d  = loop_max_q;
        pass_fail_d = pass_fail_q;
        stalled_d   = stalled_q;
        start_acc   = 1'b0;
        syn_upd     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_dec) begin
                    state_d     = ST_ITER;
                    start_acc   = 1'b1;
                    iter_cnt_d  = '0;
                    pass_fail_d = 1'b0;
                    stalled_d   = 1'b0;
                    loop_max_d  = (bus.loop_max == '0) ? HAM_LEN'(1) : bus.loop_max;
                end
            end
            ST_ITER: begin
                state_d = ST_WAIT_SYN;
            end
            ST_WAIT_SYN: begin
                if (bus.syn_valid) begin
                    syn_upd    = 1'b1;
                    iter_cnt_d = cnt_inc;
                    if (bus.sum_mm == '0) begin
                        state_d     = ST_DONE;
                        pass_fail_d = 1'b1;
                    end else if (cnt_inc == loop_max_q) begin
                        state_d = ST_DONE;
                    end else if (stall_hit) begin
                        state_d   = ST_DONE;
                        stalled_d = 1'b1;
                    end else begin
                        state_d = ST_ITER;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            iter_cnt_q  <= '0;
            loop_max_q  <= HAM_LEN'(1);
            pass_fail_q <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_cnt_q  <= iter_cnt_d;
            loop_max_q  <= loop_max_d;
            pass_fail_q <= pass_fail_d;
            stalled_q   <= stalled_d;
        end
    end

    assign bus.iter_start = (state_q == ST_ITER);
    assign bus.busy       = (state_q == ST_ITER) || (state_q == ST_WAIT_SYN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.pass_fail  = pass_fail_q;
    assign bus.stalled    = stalled_q;
    assign bus.iter_cnt   = iter_cnt_q;

endmodule

// File: tb/tb_sntc_ldpc_iter_ctrl.sv
// Randomized bench for sntc_ldpc_iter_ctrl; its reference model follows
// SNTC_ITER_STALL_DET_EN the same way the design does.
module tb_sntc_ldpc_iter_ctrl;

    localparam int SUM_LEN = 8;
    localparam int HAM_LEN = 16;
    localparam int FRAC    = 8;

    logic clk = 1'b0;
    logic clr;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   seq_q[$];

    always #5 clk = ~clk;

    sntc_ldpc_iter_ctrl_if #(.SUM_LEN(SUM_LEN), .HAM_LEN(HAM_LEN)) bus ();

    sntc_ldpc_iter_ctrl #(
        .MM       (168),
        .SUM_LEN  (SUM_LEN),
        .HAM_LEN  (HAM_LEN),
        .IIR_FRAC (FRAC)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the syndrome weights as the datapath reports them and
    // decide how the codeword ends, using integer arithmetic on a scaled average.
    task automatic modelRun(input int lm, input int k, input int lim,
                            output int n, output bit pass, output bit stl);
        int eff;
        int iir;
        int run;
        int s;
        eff  = (lm == 0) ? 1 : lm;
        iir  = 0;
        run  = 0;
        n    = 0;
        pass = 1'b0;
        stl  = 1'b0;
        for (int i = 0; i < seq_q.size(); i++) begin
            s = seq_q[i] * (1 << FRAC);
            n = i + 1;
            if (seq_q[i] == 0) begin
                pass = 1'b1;
                return;
            end
            if (n == eff) return;
`ifdef SNTC_ITER_STALL_DET_EN
            if (i == 0) begin
                iir = s;
            end else begin
                run = (s >= iir) ? run + 1 : 0;
                iir = iir + ((s - iir) >>> k);
            end
            if (lim != 0 && run == lim) begin
                stl = 1'b1;
                return;
            end
`else
            if (k < 0 || lim < 0) return;
`endif
        end
    endtask

    // Runs one codeword with the bench acting as host and datapath; noisy mode
    // keeps hitting start_dec while the decode is in progress.
    task automatic applyStimulus(input int lm, input int k, input int lim, input bit noisy);
        int exp_n;
        bit exp_pass;
        bit exp_stl;
        int pulses = 0;
        int idx = 0;
        int pend = 0;
        bit syn_prev = 1'b0;
        bit done_seen = 1'b0;

        modelRun(lm, k, lim, exp_n, exp_pass, exp_stl);

        bus.start_dec   = 1'b1;
        bus.loop_max    = HAM_LEN'(lm);
        bus.stall_shift = 3'(k);
        bus.stall_limit = 4'(lim);
        step();
        bus.start_dec = 1'b0;
        checkOutput("start_to_iter_start", bus.iter_start, 1);
        checkOutput("busy_after_start", bus.busy, 1);
        checkOutput("iter_cnt_cleared", bus.iter_cnt, 0);
        checkOutput("pass_fail_cleared", bus.pass_fail, 0);
        checkOutput("stalled_cleared", bus.stalled, 0);

        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.syn_valid = 1'b0;
            bus.start_dec = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (bus.done) begin
                done_seen = 1'b1;
                break;
            end
            if (syn_prev) checkOutput("syn_to_iter_start", bus.iter_start, 1);
            if (bus.iter_start) begin
                pulses++;
                pend = 1 + $urandom_range(0, 3);
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.syn_valid = 1'b1;
                    bus.sum_mm    = (idx < seq_q.size()) ? SUM_LEN'(seq_q[idx]) : SUM_LEN'(7);
                    idx++;
                end
            end
            syn_prev = bus.syn_valid;
            step();
        end

        checkOutput("done_seen", done_seen, 1);
        checkOutput("syn_to_done", syn_prev, 1);
        checkOutput("pass_fail", bus.pass_fail, exp_pass);
        checkOutput("stalled", bus.stalled, exp_stl);
        checkOutput("iter_cnt", bus.iter_cnt, exp_n);
        checkOutput("iter_start_pulses", pulses, exp_n);
        checkOutput("syn_valid_used", idx, exp_n);

        step();
        bus.start_dec = 1'b0;
        checkOutput("done_one_cycle", bus.done, 0);
        checkOutput("no_restart_from_done", bus.iter_start, 0);
        checkOutput("busy_after_done", bus.busy, 0);
        checkOutput("pass_fail_held", bus.pass_fail, exp_pass);
        step();
    endtask

    task automatic strayTest();
        logic [HAM_LEN-1:0] cnt_before;
        cnt_before = bus.iter_cnt;
        for (int i = 0; i < 4; i++) begin
            bus.syn_valid = 1'b1;
            bus.sum_mm    = SUM_LEN'($urandom_range(0, 168));
            step();
            checkOutput("stray_syn_iter_start", bus.iter_start, 0);
            checkOutput("stray_syn_done", bus.done, 0);
            checkOutput("stray_syn_iter_cnt", bus.iter_cnt, cnt_before);
        end
        bus.syn_valid = 1'b0;
    endtask

    // Two iterations, then clr while waiting on the syndrome; a late
    // syn_valid afterwards must not revive the decode.
    task automatic clearTest();
        bus.start_dec   = 1'b1;
        bus.loop_max    = HAM_LEN'(10);
        bus.stall_shift = 3'd0;
        bus.stall_limit = 4'd0;
        bus.sum_mm      = SUM_LEN'(9);
        step();
        bus.start_dec = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            bus.syn_valid = 1'b1;
            step();
            bus.syn_valid = 1'b0;
            checkOutput("clr_pre_iter_start", bus.iter_start, 1);
        end
        step();
        checkOutput("clr_pre_iter_cnt", bus.iter_cnt, 2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        checkOutput("clr_iter_start", bus.iter_start, 0);
        checkOutput("clr_busy", bus.busy, 0);
        checkOutput("clr_done", bus.done, 0);
        checkOutput("clr_pass_fail", bus.pass_fail, 0);
        checkOutput("clr_stalled", bus.stalled, 0);
        checkOutput("clr_iter_cnt", bus.iter_cnt, 0);
        bus.syn_valid = 1'b1;
        step();
        bus.syn_valid = 1'b0;
        checkOutput("late_syn_iter_start", bus.iter_start, 0);
        checkOutput("late_syn_iter_cnt", bus.iter_cnt, 0);
        step();
        checkOutput("late_syn_done", bus.done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lm;
        int k;
        int lim;
        int eff;
        int mode;
        int base;
        int v;

        clr             = 1'b1;
        bus.start_dec   = 1'b0;
        bus.loop_max    = '0;
        bus.stall_shift = 3'd0;
        bus.stall_limit = 4'd0;
        bus.syn_valid   = 1'b0;
        bus.sum_mm      = '0;
        repeat (3) step();
        checkOutput("reset_iter_start", bus.iter_start, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_pass_fail", bus.pass_fail, 0);
        checkOutput("reset_stalled", bus.stalled, 0);
        checkOutput("reset_iter_cnt", bus.iter_cnt, 0);
        clr = 1'b0;
        step();

        seq_q = '{4, 2, 0, 5, 5};
        applyStimulus(5, 0, 0, 1'b0);
        seq_q = '{7, 7, 7, 7};
        applyStimulus(4, 2, 0, 1'b0);
        seq_q = '{10, 10, 10, 10, 10, 10};
        applyStimulus(6, 1, 2, 1'b0);
        seq_q = '{3};
        applyStimulus(0, 0, 0, 1'b0);
        seq_q = '{20, 15, 15, 15, 15, 15, 15};
        applyStimulus(7, 3, 3, 1'b1);
        strayTest();
        clearTest();

        for (int t = 0; t < 40; t++) begin
            lm   = $urandom_range(0, 8);
            k    = $urandom_range(0, 7);
            lim  = $urandom_range(0, 4);
            mode = $urandom_range(0, 2);
            base = $urandom_range(1, 168);
            eff  = (lm == 0) ? 1 : lm;
            seq_q.delete();
            for (int i = 0; i < eff; i++) begin
                case (mode)
                    0: v = base;
                    1: v = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 168);
                    default: v = (base > i * 10) ? base - i * 10 : $urandom_range(0, 3);
                endcase
                seq_q.push_back(v);
            end
            applyStimulus(lm, k, lim, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sntc_ldpc_iter_ctrl.md
SNTC_LDPC_ITER_CTRL -- requirements
Module: sntc_ldpc_iter_ctrl

Interface
REQ-001 Parameter MM, default 'h000a8: syndrome length in bits.
REQ-002 Parameter SUM_LEN, default $clog2(MM+1): width of the syndrome Hamming-distance input.
REQ-003 Parameter HAM_LEN, default 16: width of the iteration counter and the loop limit.
REQ-004 Parameter IIR_FRAC, default 8: fractional bits of the stall IIR accumulator.
REQ-005 clk  in  1  sole clock; all logic on posedge clk.
REQ-006 clr  in  1  reset: synchronous, active-high.
REQ-007 start_dec  in  1  pulse; begins decoding one codeword.
REQ-008 loop_max  in  HAM_LEN  maximum iterations; sampled on accepted start_dec.
REQ-009 stall_shift  in  3  IIR smoothing shift K (0..7); sampled on accepted start_dec.
REQ-010 stall_limit  in  4  consecutive non-improving iterations to declare stall; 0 disables; sampled on accepted start_dec.
REQ-011 iter_start  out  1  one-cycle pulse to the datapath to run one iteration.
REQ-012 syn_valid  in  1  pulse; sum_mm is valid for the iteration just run.
REQ-013 sum_mm  in  SUM_LEN  Hamming distance between current and expected syndrome.
REQ-014 busy  out  1  high from the cycle after accepted start_dec until done.
REQ-015 done  out  1  one-cycle pulse; codeword finished.
REQ-016 pass_fail  out  1  1 = converged (sum_mm==0); held until next accepted start_dec.
REQ-017 stalled  out  1  1 = terminated by stall detection; held like pass_fail.
REQ-018 iter_cnt  out  HAM_LEN  completed iterations of the current/last codeword.

Function
REQ-019 FSM states IDLE, ITER, WAIT_SYN, DONE; state register reset to IDLE.
REQ-020 IDLE: start_dec=1 -> ITER; clear iter_cnt, pass_fail, stalled, stall counter; latch config; loop_max of 0 latched as 1.
REQ-021 start_dec in any state other than IDLE is ignored.
REQ-022 ITER: drive iter_start=1 for exactly one cycle, then WAIT_SYN.
REQ-023 WAIT_SYN: no action until syn_valid; syn_valid in any other state is ignored.
REQ-024 On syn_valid in WAIT_SYN: iter_cnt increments by 1; evaluate, in priority order: sum_mm==0 -> DONE, pass_fail=1; iter_cnt+1 == loop_max -> DONE, pass_fail=0; stall detected -> DONE, stalled=1; else ITER.
REQ-025 DONE: done=1 for one cycle, then IDLE; a start_dec in the DONE cycle is ignored.
REQ-026 Latency: start_dec to first iter_start = 1 cycle; syn_valid to next iter_start = 1 cycle; syn_valid to done = 1 cycle.
REQ-027 iter_cnt saturates at all-ones and never wraps.

Reset
REQ-028 clr=1 at any clock edge, including mid-decode: state=IDLE, iter_start=0, busy=0, done=0, pass_fail=0, stalled=0, iter_cnt=0, IIR=0, stall counter=0; clr has priority over all inputs.

Configuration
REQ-029 Macro SNTC_ITER_STALL_DET_EN: when defined, IIR stall detection (REQ-030..REQ-032) is built in.
REQ-030 IIR accumulator width SUM_LEN+IIR_FRAC, unsigned; on the first syn_valid of a codeword it loads sum_mm<<IIR_FRAC.
REQ-031 On each later syn_valid: IIR <= IIR + (((sum_mm<<IIR_FRAC) - IIR) >>> K), computed signed one bit wider; the compare uses the IIR value before update.
REQ-032 Stall counter increments when (sum_mm<<IIR_FRAC) >= IIR (pre-update), else clears; stall detected when stall_limit!=0 and the counter reaches stall_limit.
REQ-033 Without the macro: no IIR or stall-counter logic; stalled is tied to 0; stall_shift and stall_limit are unused.

Structure
REQ-034 Package sntc_ldpc_iter_pkg holds the FSM state enum and the IIR_FRAC default.
REQ-035 One sub-module, sntc_ldpc_stall_iir, contains the IIR accumulator and stall counter; instantiated only under SNTC_ITER_STALL_DET_EN.

Verification
REQ-036 loop_max=5, sum_mm=0 on the 3rd syn_valid -> done one cycle later, pass_fail=1, iter_cnt=3, exactly 3 iter_start pulses.
REQ-037 loop_max=4, sum_mm always 7, stall_limit=0 -> done after 4th syn_valid, pass_fail=0, stalled=0, iter_cnt=4.
REQ-038 Macro on, K=1, stall_limit=2, sum_mm sequence 10,10,10 -> stalled=1 after 3rd syn_valid, iter_cnt=3; macro off -> continues to loop_max.
REQ-039 clr asserted in WAIT_SYN after 2 iterations -> next cycle all outputs 0, state IDLE; a late syn_valid produces no iter_start.
REQ-040 start_dec repeated while busy, and stray syn_valid in IDLE -> no effect on iter_cnt, iter_start or done.
REQ-041 loop_max=0 with sum_mm=3 -> exactly one iteration, done, pass_fail=0, iter_cnt=1.
